floo_mcast_b_reducer: RTL and testbench

// - Sits at the initiator side of the multicast mesh NoC, between the chimney's B-channel output and the AXI manager.
// - A multicast AW fans out to N destinations and each destination returns its own B.
// - This block tracks every outstanding multicast write per AXI ID and counts the returning Bs.
// - It emits exactly one merged B per write, carrying the worst-case response.

---
 rtl/floo_pkg.sv | 43 ++++
 rtl/floo_mcast_b_reducer_if.sv | 53 +++++
 rtl/floo_mcast_b_reducer_entry.sv | 65 ++++++
 rtl/floo_mcast_b_reducer.sv | 127 ++++++++++++
 tb/tb_floo_mcast_b_reducer.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/floo_pkg.sv
// ============================================================================
// Module      : floo_pkg
// Description : Shared FlooNoC definitions. Holds the AXI B-response encodings,
//               the multicast B-reducer entry state type, and the worst-case
//               B-response merge function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package floo_pkg;

    // AXI response encodings
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } mcast_b_state_e;

    // Severity rank of a response: EXOKAY < OKAY < SLVERR < DECERR.
    // EXOKAY and OKAY are swapped relative to their encodings; the error
    // codes already sort by severity.
    function automatic logic [1:0] bresp_rank(input logic [1:0] resp);
        logic [1:0] rank;
        case (resp)
            AXI_RESP_EXOKAY: rank = 2'd0;
            AXI_RESP_OKAY:   rank = 2'd1;
            default:         rank = resp;
        endcase
        return rank;
    endfunction

    // Returns the more severe of two responses. EXOKAY is the identity.
    function automatic logic [1:0] merge_bresp(input logic [1:0] a, input logic [1:0] b);
        return (bresp_rank(a) >= bresp_rank(b)) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/floo_mcast_b_reducer_if.sv
// ============================================================================
// Module      : floo_mcast_b_reducer_if
// Description : Bus bundle for the multicast B reducer.
//               AW tracking: aw_valid_i / aw_ready_o / aw_id_i / aw_ndst_i
//               NoC B in   : b_valid_i / b_ready_o / b_id_i / b_resp_i
//               Merged B   : b_valid_o / b_ready_i / b_id_o / b_resp_o
//               slave  = reducer view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface floo_mcast_b_reducer_if #(
    parameter int unsigned IdWidth  = 4,
    parameter int unsigned MaxDst   = 16,
    parameter int unsigned CntWidth = $clog2(MaxDst + 1)
) ();

    logic                aw_valid_i;
    logic                aw_ready_o;
    logic [IdWidth-1:0]  aw_id_i;
    logic [CntWidth-1:0] aw_ndst_i;

    logic                b_valid_i;
    logic                b_ready_o;
    logic [IdWidth-1:0]  b_id_i;
    logic [1:0]          b_resp_i;

    logic                b_valid_o;
    logic                b_ready_i;
    logic [IdWidth-1:0]  b_id_o;
    logic [1:0]          b_resp_o;

    modport slave (
        input  aw_valid_i, aw_id_i, aw_ndst_i,
        output aw_ready_o,
        input  b_valid_i, b_id_i, b_resp_i,
        output b_ready_o,
        output b_valid_o, b_id_o, b_resp_o,
        input  b_ready_i
    );

    modport master (
        output aw_valid_i, aw_id_i, aw_ndst_i,
        input  aw_ready_o,
        output b_valid_i, b_id_i, b_resp_i,
        input  b_ready_o,
        input  b_valid_o, b_id_o, b_resp_o,
        output b_ready_i
    );

endinterface

`default_nettype wire

// File: rtl/floo_mcast_b_reducer_entry.sv
// ============================================================================
// Module      : floo_mcast_b_entry
// Description : Per-ID tracker of one outstanding multicast write. Holds the
//               IDLE/COLLECT state, the remaining-B counter and the merged
//               response so far.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   aw_load_i     : allocate (only asserted while idle), aw_ndst_i = B count
//   b_hit_i       : B accepted for this entry (only asserted while collecting)
//   b_resp_i      : response of that B
//   idle_o        : entry free
//   last_o        : next accepted B completes the write
//   merged_o      : accumulated response merged with b_resp_i
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module floo_mcast_b_entry
    import floo_pkg::*;
#(
    parameter int unsigned CntWidth = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                aw_load_i,
    input  logic [CntWidth-1:0] aw_ndst_i,
    input  logic                b_hit_i,
    input  logic [1:0]          b_resp_i,
    output logic                idle_o,
    output logic                last_o,
    output logic [1:0]          merged_o
);

    localparam logic [0:0] ST_IDLE    = 1'(IDLE);
    localparam logic [0:0] ST_COLLECT = 1'(COLLECT);

    logic [0:0]          r_state;
    logic [CntWidth-1:0] r_cnt;
    logic [1:0]          r_acc;

    assign idle_o   = (r_state == ST_IDLE);
    assign last_o   = (r_cnt == CntWidth'(1));
    assign merged_o = merge_bresp(r_acc, b_resp_i);

    // Load and hit never coincide: load needs IDLE, hit needs COLLECT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= AXI_RESP_OKAY;
        end else if (aw_load_i) begin
            r_state <= ST_COLLECT;
            r_cnt   <= aw_ndst_i;
            r_acc   <= AXI_RESP_EXOKAY;
        end else if (b_hit_i) begin
            r_cnt <= r_cnt - CntWidth'(1);
            r_acc <= merged_o;
            if (last_o) begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/floo_mcast_b_reducer.sv
// ============================================================================
// Module      : floo_mcast_b_reducer
// Description : Collects the per-destination B responses of multicast writes
//               and emits one merged (worst-case) B per write. One tracker
//               entry per AXI ID; one B input and at most one completion per
//               cycle; merged B registered (1 cycle after the last B).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : floo_mcast_b_reducer_if.slave (AW track, B in, merged B)
//   busy_o        : at least one entry is collecting
//   stray_cnt_o   : saturating count of Bs hitting an idle entry
//                   (only with FLOO_MCAST_B_STRAY_CNT_EN defined)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module floo_mcast_b_reducer
    import floo_pkg::*;
#(
    parameter int unsigned IdWidth  = 4,
    parameter int unsigned MaxDst   = 16,
    parameter int unsigned CntWidth = $clog2(MaxDst + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    floo_mcast_b_reducer_if.slave         bus,
`ifdef FLOO_MCAST_B_STRAY_CNT_EN
    output logic [15:0]                   stray_cnt_o,
`endif
    output logic                          busy_o
);

    localparam int unsigned NumIds = 2 ** IdWidth;

    logic [NumIds-1:0] w_idle;
    logic [NumIds-1:0] w_last;
    logic [NumIds-1:0] w_load;
    logic [NumIds-1:0] w_hit;
    logic [1:0]        w_merged [NumIds];

    logic w_aw_hs, w_b_hs, w_ndst_nz, w_b_idle, w_complete, w_stray;

    logic               r_b_valid;
    logic [IdWidth-1:0] r_b_id;
    logic [1:0]         r_b_resp;

    assign bus.aw_ready_o = w_idle[bus.aw_id_i];
    // Stall every incoming B while the output register is blocked; simpler
    // than distinguishing completing from non-completing Bs.
    assign bus.b_ready_o  = ~r_b_valid | bus.b_ready_i;

    assign w_aw_hs    = bus.aw_valid_i & bus.aw_ready_o;
    assign w_b_hs     = bus.b_valid_i & bus.b_ready_o;
    assign w_ndst_nz  = |bus.aw_ndst_i;
    assign w_b_idle   = w_idle[bus.b_id_i];
    assign w_complete = w_b_hs & ~w_b_idle & w_last[bus.b_id_i];
    assign w_stray    = w_b_hs & w_b_idle;

    generate
        for (genvar gi = 0; gi < NumIds; gi++) begin : g_entry
            // A zero-destination AW is accepted but allocates nothing.
            assign w_load[gi] = w_aw_hs & w_ndst_nz & (bus.aw_id_i == IdWidth'(gi));
            assign w_hit[gi]  = w_b_hs & ~w_idle[gi] & (bus.b_id_i == IdWidth'(gi));

            floo_mcast_b_entry #(
                .CntWidth (CntWidth)
            ) u_entry (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .aw_load_i (w_load[gi]),
                .aw_ndst_i (bus.aw_ndst_i),
                .b_hit_i   (w_hit[gi]),
                .b_resp_i  (bus.b_resp_i),
                .idle_o    (w_idle[gi]),
                .last_o    (w_last[gi]),
                .merged_o  (w_merged[gi])
            );
        end
    endgenerate

    // Merged-B output register. A completion can only arrive when the
    // register is empty or being drained, so it never overwrites a live B.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_b_valid <= 1'b0;
            r_b_id    <= '0;
            r_b_resp  <= AXI_RESP_OKAY;
        end else if (w_complete) begin
            r_b_valid <= 1'b1;
            r_b_id    <= bus.b_id_i;
            r_b_resp  <= w_merged[bus.b_id_i];
        end else if (bus.b_ready_i) begin
            r_b_valid <= 1'b0;
        end
    end

    assign bus.b_valid_o = r_b_valid;
    assign bus.b_id_o    = r_b_id;
    assign bus.b_resp_o  = r_b_resp;
    assign busy_o        = ~&w_idle;

`ifdef FLOO_MCAST_B_STRAY_CNT_EN
    logic [15:0] r_stray_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stray_cnt <= '0;
        end else if (w_stray && (r_stray_cnt != 16'hFFFF)) begin
            r_stray_cnt <= r_stray_cnt + 16'd1;
        end
    end

    assign stray_cnt_o = r_stray_cnt;
`endif

`ifndef SYNTHESIS
    a_ndst_nonzero : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_aw_hs && !w_ndst_nz))
        else $warning("floo_mcast_b_reducer: multicast AW with zero destinations");

    a_no_stray_b : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !w_stray)
        else $warning("floo_mcast_b_reducer: B received for an idle ID, consumed");
`endif

endmodule

`default_nettype wire

// File: tb/tb_floo_mcast_b_reducer.sv
// ============================================================================
// Module      : tb_floo_mcast_b_reducer
// Description : Self-checking bench for floo_mcast_b_reducer. A queue-based
//               reference model tracks outstanding writes per ID and the
//               expected sequence of merged Bs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_floo_mcast_b_reducer;
    import floo_pkg::*;

    localparam int ID_W    = 4;
    localparam int NUM_IDS = 16;
    localparam int CNT_W   = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
`ifdef FLOO_MCAST_B_STRAY_CNT_EN
    logic [15:0] stray_cnt;
`endif

    always #5 clk = ~clk;

    floo_mcast_b_reducer_if #(.IdWidth(ID_W), .MaxDst(16)) bus ();

    floo_mcast_b_reducer #(
        .IdWidth (ID_W),
        .MaxDst  (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
`ifdef FLOO_MCAST_B_STRAY_CNT_EN
        .stray_cnt_o (stray_cnt),
`endif
        .busy_o      (busy)
    );

    // ---------------- reference model ----------------
    // Severity of each encoding (index = resp code) and its inverse.
    int         rank_tab [4] = '{1, 0, 2, 3};
    logic [1:0] resp_tab [4] = '{2'b01, 2'b00, 2'b10, 2'b11};

    int pend_cnt  [NUM_IDS];
    int pend_rank [NUM_IDS];
    int exp_q [$];
    int obs_q [$];
    int stray_model;
    bit rand_ready;
    bit last_aw_hs, last_b_hs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] t2_seq  [3][3] = '{'{2'b00, 2'b10, 2'b01},
                                   '{2'b01, 2'b01, 2'b01},
                                   '{2'b00, 2'b11, 2'b10}};
    logic [1:0] t2_want [3]    = '{2'b10, 2'b01, 2'b11};

    task automatic model_reset();
        for (int i = 0; i < NUM_IDS; i++) begin
            pend_cnt[i]  = 0;
            pend_rank[i] = 0;
        end
        exp_q.delete();
        obs_q.delete();
        stray_model = 0;
    endtask

    // One clock: sample handshakes mid-cycle, update the model, advance.
    task automatic tick();
        bit aw_hs, b_hs;
        int id;
        if (rand_ready) bus.b_ready_i = ($urandom_range(0, 3) != 0);
        #1;
        aw_hs = bus.aw_valid_i && bus.aw_ready_o;
        b_hs  = bus.b_valid_i && bus.b_ready_o;
        if (bus.b_valid_o && bus.b_ready_i)
            obs_q.push_back(int'(bus.b_id_o) * 4 + int'(bus.b_resp_o));
        if (b_hs) begin
            id = int'(bus.b_id_i);
            if (pend_cnt[id] == 0) begin
                stray_model++;
            end else begin
                pend_cnt[id]--;
                if (rank_tab[bus.b_resp_i] > pend_rank[id]) pend_rank[id] = rank_tab[bus.b_resp_i];
                if (pend_cnt[id] == 0) exp_q.push_back(id * 4 + int'(resp_tab[pend_rank[id]]));
            end
        end
        if (aw_hs && bus.aw_ndst_i != '0) begin
            pend_cnt[int'(bus.aw_id_i)]  = int'(bus.aw_ndst_i);
            pend_rank[int'(bus.aw_id_i)] = 0;
        end
        last_aw_hs = aw_hs;
        last_b_hs  = b_hs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_aw(input int id, input int ndst);
        bus.aw_valid_i = 1'b1;
        bus.aw_id_i    = ID_W'(id);
        bus.aw_ndst_i  = CNT_W'(ndst);
        for (int k = 0; k < 200; k++) begin
            tick();
            if (last_aw_hs) break;
        end
        if (!last_aw_hs) begin
            n_checks++; n_fail++;
            $display("FAIL aw_timeout id=%0d: no AW handshake, required within 200 cycles", id);
        end
        bus.aw_valid_i = 1'b0;
    endtask

    task automatic do_b(input int id, input logic [1:0] resp);
        bus.b_valid_i = 1'b1;
        bus.b_id_i    = ID_W'(id);
        bus.b_resp_i  = resp;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (last_b_hs) break;
        end
        if (!last_b_hs) begin
            n_checks++; n_fail++;
            $display("FAIL b_timeout id=%0d: no B handshake, required within 200 cycles", id);
        end
        bus.b_valid_i = 1'b0;
    endtask

    task automatic drain();
        rand_ready    = 1'b0;
        bus.b_ready_i = 1'b1;
        for (int k = 0; k < 20 && bus.b_valid_o; k++) tick();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.aw_valid_i = 0; bus.aw_id_i = '0; bus.aw_ndst_i = '0;
        bus.b_valid_i = 0; bus.b_id_i = '0; bus.b_resp_i = '0;
        bus.b_ready_i = 1'b0;
        rand_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus.aw_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_aw_ready: got %b want 1", bus.aw_ready_o); end
        n_checks++; if (bus.b_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready: got %b want 1", bus.b_ready_o); end
        n_checks++; if (bus.b_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: got %b want 0", bus.b_valid_o); end
        n_checks++; if (bus.b_id_o !== 4'd0 || bus.b_resp_o !== 2'd0) begin n_fail++; $display("FAIL reset_b_payload: got id=%0d resp=%0d want 0/0", bus.b_id_o, bus.b_resp_o); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef FLOO_MCAST_B_STRAY_CNT_EN
        n_checks++; if (stray_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stray_cnt: got %0d want 0", stray_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        bus.b_ready_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_merge();
        model_reset();
        do_aw(3, 4);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", busy); end
        for (int k = 0; k < 4; k++) begin
            do_b(3, AXI_RESP_OKAY);
            if (k < 3) begin
                n_checks++; if (bus.b_valid_o !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid b%0d: got %b want 0", k, bus.b_valid_o); end
            end else begin
                n_checks++;
                if (bus.b_valid_o !== 1'b1 || bus.b_id_o !== 4'd3 || bus.b_resp_o !== AXI_RESP_OKAY) begin
                    n_fail++; $display("FAIL t1_merged: got v=%b id=%0d resp=%0d want v=1 id=3 resp=0", bus.b_valid_o, bus.b_id_o, bus.b_resp_o);
                end
            end
        end
        drain();
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL t1_count: got %0d Bs want 1", obs_q.size()); end
        n_checks++; if (obs_q.size() > 0 && obs_q[0] != exp_q[0]) begin n_fail++; $display("FAIL t1_model: got %0d want %0d", obs_q[0], exp_q[0]); end
    endtask

    task automatic test_worst_resp();
        for (int s = 0; s < 3; s++) begin
            model_reset();
            do_aw(1, 3);
            for (int k = 0; k < 3; k++) do_b(1, t2_seq[s][k]);
            n_checks++;
            if (bus.b_valid_o !== 1'b1 || bus.b_id_o !== 4'd1 || bus.b_resp_o !== t2_want[s]) begin
                n_fail++; $display("FAIL t2_resp set%0d: got v=%b id=%0d resp=%0d want v=1 id=1 resp=%0d", s, bus.b_valid_o, bus.b_id_o, bus.b_resp_o, t2_want[s]);
            end
            drain();
            n_checks++;
            if (obs_q.size() != 1 || obs_q[0] != exp_q[0]) begin
                n_fail++; $display("FAIL t2_model set%0d: got %0d Bs want 1 matching model", s, obs_q.size());
            end
        end
    endtask

    task automatic test_id_reuse();
        model_reset();
        do_aw(3, 2);
        bus.aw_valid_i = 1'b1; bus.aw_id_i = 4'd3; bus.aw_ndst_i = 5'd1;
        #1;
        n_checks++; if (bus.aw_ready_o !== 1'b0) begin n_fail++; $display("FAIL t3_busy_id: got aw_ready=%b want 0", bus.aw_ready_o); end
        do_b(3, AXI_RESP_OKAY);
        n_checks++; if (bus.aw_ready_o !== 1'b0 || last_aw_hs) begin n_fail++; $display("FAIL t3_mid: got aw_ready=%b want 0", bus.aw_ready_o); end
        do_b(3, AXI_RESP_SLVERR);
        #1;
        n_checks++; if (bus.aw_ready_o !== 1'b1) begin n_fail++; $display("FAIL t3_freed: got aw_ready=%b want 1", bus.aw_ready_o); end
        tick();
        n_checks++; if (!last_aw_hs) begin n_fail++; $display("FAIL t3_reaccept: got hs=0 want 1"); end
        bus.aw_valid_i = 1'b0;
        do_b(3, AXI_RESP_OKAY);
        drain();
        n_checks++;
        if (obs_q.size() != 2 || obs_q[0] != 3*4+2 || obs_q[1] != 3*4+0) begin
            n_fail++; $display("FAIL t3_seq: got %0d Bs want 2 (id3 SLVERR, id3 OKAY)", obs_q.size());
        end
    endtask

    task automatic test_backpressure();
        model_reset();
        bus.b_ready_i = 1'b0;
        do_aw(5, 1);
        do_aw(6, 2);
        do_b(5, AXI_RESP_SLVERR);
        n_checks++;
        if (bus.b_valid_o !== 1'b1 || bus.b_id_o !== 4'd5 || bus.b_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL t4_stall: got v=%b id=%0d b_ready_o=%b want v=1 id=5 b_ready_o=0", bus.b_valid_o, bus.b_id_o, bus.b_ready_o);
        end
        bus.b_valid_i = 1'b1; bus.b_id_i = 4'd6; bus.b_resp_i = AXI_RESP_OKAY;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (last_b_hs || bus.b_valid_o !== 1'b1 || bus.b_id_o !== 4'd5 || bus.b_resp_o !== AXI_RESP_SLVERR) begin
                n_fail++; $display("FAIL t4_hold c%0d: got hs=%0b v=%b id=%0d resp=%0d want hs=0 v=1 id=5 resp=2", k, last_b_hs, bus.b_valid_o, bus.b_id_o, bus.b_resp_o);
            end
        end
        bus.b_ready_i = 1'b1;
        tick();
        n_checks++; if (!last_b_hs) begin n_fail++; $display("FAIL t4_resume: got hs=0 want 1"); end
        bus.b_valid_i = 1'b0;
        do_b(6, AXI_RESP_DECERR);
        n_checks++;
        if (bus.b_valid_o !== 1'b1 || bus.b_id_o !== 4'd6 || bus.b_resp_o !== AXI_RESP_DECERR) begin
            n_fail++; $display("FAIL t4_second: got v=%b id=%0d resp=%0d want v=1 id=6 resp=3", bus.b_valid_o, bus.b_id_o, bus.b_resp_o);
        end
        drain();
        n_checks++;
        if (obs_q.size() != 2 || obs_q[0] != 5*4+2 || obs_q[1] != exp_q[1]) begin
            n_fail++; $display("FAIL t4_seq: got %0d Bs want 2 (id5 SLVERR, id6 DECERR)", obs_q.size());
        end
    endtask

    task automatic test_interleave();
        int left [NUM_IDS];
        int total, id, start;
        model_reset();
        total = 0;
        for (int i = 0; i < NUM_IDS; i++) begin
            left[i] = $urandom_range(1, 16);
            total  += left[i];
            do_aw(i, left[i]);
        end
        rand_ready = 1'b1;
        while (total > 0) begin
            start = $urandom_range(0, NUM_IDS - 1);
            id = start;
            for (int j = 0; j < NUM_IDS; j++) begin
                id = (start + j) % NUM_IDS;
                if (left[id] > 0) break;
            end
            do_b(id, 2'($urandom_range(0, 3)));
            left[id]--;
            total--;
            if ($urandom_range(0, 7) == 0) tick();
        end
        drain();
        n_checks++; if (obs_q.size() != NUM_IDS) begin n_fail++; $display("FAIL t5_count: got %0d Bs want %0d", obs_q.size(), NUM_IDS); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] != exp_q[i]) begin
                n_fail++; $display("FAIL t5_b%0d: got id=%0d resp=%0d want id=%0d resp=%0d", i, obs_q[i]/4, obs_q[i]%4, exp_q[i]/4, exp_q[i]%4);
            end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t5_busy: got %b want 0", busy); end
    endtask

    task automatic test_stray();
        obs_q.delete();
        exp_q.delete();
        do_b(7, AXI_RESP_OKAY);
        repeat (3) tick();
        n_checks++;
        if (obs_q.size() != 0 || bus.b_valid_o !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t5_stray: got %0d Bs v=%b busy=%b want 0 Bs v=0 busy=0", obs_q.size(), bus.b_valid_o, busy);
        end
`ifdef FLOO_MCAST_B_STRAY_CNT_EN
        n_checks++; if (stray_cnt !== 16'(stray_model) || stray_cnt !== 16'd1) begin n_fail++; $display("FAIL t5_stray_cnt: got %0d want 1", stray_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        model_reset();
        do_aw(2, 3);
        do_b(2, AXI_RESP_SLVERR);
        bus.b_ready_i = 1'b0;
        do_aw(4, 1);
        do_b(4, AXI_RESP_OKAY);
        n_checks++; if (busy !== 1'b1 || bus.b_valid_o !== 1'b1) begin n_fail++; $display("FAIL t6_pre: got busy=%b v=%b want 1/1", busy, bus.b_valid_o); end
        bus.aw_id_i = 4'd2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.b_valid_o !== 1'b0 || bus.b_id_o !== 4'd0 || bus.b_resp_o !== 2'd0 || bus.b_ready_o !== 1'b1 || bus.aw_ready_o !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t6_reset: got v=%b id=%0d resp=%0d b_rdy=%b aw_rdy=%b busy=%b want 0 0 0 1 1 0", bus.b_valid_o, bus.b_id_o, bus.b_resp_o, bus.b_ready_o, bus.aw_ready_o, busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.b_ready_i = 1'b1;
        @(negedge clk);
        do_aw(3, 1);
        do_b(3, AXI_RESP_OKAY);
        n_checks++;
        if (bus.b_valid_o !== 1'b1 || bus.b_id_o !== 4'd3 || bus.b_resp_o !== AXI_RESP_OKAY) begin
            n_fail++; $display("FAIL t6_after: got v=%b id=%0d resp=%0d want v=1 id=3 resp=0", bus.b_valid_o, bus.b_id_o, bus.b_resp_o);
        end
        drain();
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL t6_count: got %0d Bs want 1", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_merge();
        test_worst_resp();
        test_id_reuse();
        test_backpressure();
        test_interleave();
        test_stray();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
